// File: rtl/fccc_lock_reset_seq.sv
// Lock supervisor and reset sequencer for the fabric CCC, clocked by the free-running CLK0.
// Sequences PLL reset, lock qualification and staggered GL0/GL1 reset release; forces relock on lock loss.
module fccc_lock_reset_seq #(
  parameter int unsigned LOCK_SYNC_STAGES   = 2,
  parameter int unsigned PLL_ARST_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DOMAIN_GAP         = 32,
  parameter int unsigned UNLOCK_FILTER      = 8,
  parameter int unsigned RELOCK_TIMEOUT     = 65536
) (
  input  logic       CLK0,
  input  logic       RESET,
  input  logic       LOCK,
  input  logic       FORCE_RELOCK,
  output logic       PLL_ARST_N,
  output logic       GL0_RESET_N,
  output logic       GL1_RESET_N,
  output logic       READY,
  output logic [7:0] LOCK_LOSS_CNT,
  output logic       TIMEOUT_ERR,
  output logic [2:0] STATE
);

  localparam int unsigned MAX_A   = (PLL_ARST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_ARST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_B   = (DOMAIN_GAP > RELOCK_TIMEOUT) ? DOMAIN_GAP : RELOCK_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LOW_W   = $clog2(UNLOCK_FILTER + 1);

  localparam logic [CNT_W-1:0] ARST_LAST = CNT_W'(PLL_ARST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOMAIN_GAP - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(RELOCK_TIMEOUT - 1);
  localparam logic [LOW_W-1:0] FILT_LAST = LOW_W'(UNLOCK_FILTER - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_GL0   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                state, nxt;
  logic [LOCK_SYNC_STAGES-1:0] sync;
  logic                  lock_s;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [LOW_W-1:0]      low, low_nxt;
  logic                  timeout, loss;
  logic                  pll_q, gl0_q, run_q, err_q;
  logic [7:0]            loss_cnt;

  assign lock_s = sync[LOCK_SYNC_STAGES-1];

  always_comb begin
    nxt     = state;
    timeout = 1'b0;
    loss    = 1'b0;
    low_nxt = '0;
    cnt_nxt = '0;
    case (state)
      PLL_RST: begin
        if (cnt == ARST_LAST) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (FORCE_RELOCK) nxt = PLL_RST;
        else if (cnt == TMO_LAST) begin
          nxt     = PLL_RST;
          timeout = 1'b1;
        end
        else if (lock_s) nxt = STABLE;
      end
      STABLE: begin
        if (FORCE_RELOCK) nxt = PLL_RST;
        else if (!lock_s) nxt = WAIT_LOCK;
        else if (cnt == STAB_LAST) nxt = REL_GL0;
      end
      REL_GL0, RUN: begin
        if (FORCE_RELOCK) nxt = PLL_RST;
        else if (!lock_s && (low == FILT_LAST)) begin
          nxt  = WAIT_LOCK;
          loss = 1'b1;
        end
        else if ((state == REL_GL0) && (cnt == GAP_LAST)) nxt = RUN;
      end
      default: nxt = PLL_RST;
    endcase

    // The low-run filter spans REL_GL0 and RUN, so it is not cleared on that entry.
    if (((nxt == REL_GL0) || (nxt == RUN)) && !lock_s) low_nxt = low + 1'b1;

    if (nxt != state)    cnt_nxt = '0;
    else if (state == RUN) cnt_nxt = cnt;
    else                 cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge CLK0) begin
    if (RESET) begin
      state    <= PLL_RST;
      sync     <= '0;
      cnt      <= '0;
      low      <= '0;
      pll_q    <= 1'b0;
      gl0_q    <= 1'b0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      loss_cnt <= '0;
    end
    else begin
      sync  <= {sync[LOCK_SYNC_STAGES-2:0], LOCK};
      state <= nxt;
      cnt   <= cnt_nxt;
      low   <= low_nxt;
      pll_q <= (nxt != PLL_RST);
      gl0_q <= (nxt == REL_GL0) || (nxt == RUN);
      run_q <= (nxt == RUN);
      if (loss && (loss_cnt != 8'hFF)) loss_cnt <= loss_cnt + 8'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign PLL_ARST_N    = pll_q;
  assign GL0_RESET_N   = gl0_q;
  assign GL1_RESET_N   = run_q;
  assign READY         = run_q;
  assign LOCK_LOSS_CNT = loss_cnt;
  assign TIMEOUT_ERR   = err_q;
  assign STATE         = state;

endmodule

// File: tb/tb_fccc_lock_reset_seq.sv
// Directed scenarios plus randomized LOCK/FORCE_RELOCK traffic, checked every cycle against a
// phase/duration reference model and at key points against fixed timing expectations.
module tb_fccc_lock_reset_seq;

  localparam int SYNC = 2;
  localparam int ARST = 8;
  localparam int STAB = 16;
  localparam int GAP  = 4;
  localparam int FILT = 4;
  localparam int TMO  = 100;

  logic       CLK0 = 1'b0;
  logic       RESET = 1'b1;
  logic       LOCK = 1'b1;
  logic       FORCE_RELOCK = 1'b0;
  logic       PLL_ARST_N, GL0_RESET_N, GL1_RESET_N, READY, TIMEOUT_ERR;
  logic [7:0] LOCK_LOSS_CNT;
  logic [2:0] STATE;

  int checks = 0;
  int failures = 0;

  fccc_lock_reset_seq #(
    .LOCK_SYNC_STAGES  (SYNC),
    .PLL_ARST_CYCLES   (ARST),
    .LOCK_STABLE_CYCLES(STAB),
    .DOMAIN_GAP        (GAP),
    .UNLOCK_FILTER     (FILT),
    .RELOCK_TIMEOUT    (TMO)
  ) dut (
    .CLK0         (CLK0),
    .RESET        (RESET),
    .LOCK         (LOCK),
    .FORCE_RELOCK (FORCE_RELOCK),
    .PLL_ARST_N   (PLL_ARST_N),
    .GL0_RESET_N  (GL0_RESET_N),
    .GL1_RESET_N  (GL1_RESET_N),
    .READY        (READY),
    .LOCK_LOSS_CNT(LOCK_LOSS_CNT),
    .TIMEOUT_ERR  (TIMEOUT_ERR),
    .STATE        (STATE)
  );

  always #5 CLK0 = ~CLK0;

  // Reference model: phase 0..4, time spent in phase, run of synced-low cycles, LOCK history.
  int m_phase, m_t, m_low, m_loss;
  bit m_err;
  bit m_hist[$];

  always @(posedge CLK0) begin : model
    bit ls;
    int np;
    int run;
    bit lost;
    if (RESET) begin
      m_phase = 0;
      m_t     = 0;
      m_low   = 0;
      m_loss  = 0;
      m_err   = 0;
      m_hist  = {};
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    end
    else begin
      ls = m_hist.pop_front();
      m_hist.push_back(LOCK);
      np   = m_phase;
      lost = 0;
      run  = (m_phase >= 3 && !ls) ? m_low + 1 : 0;
      if (FORCE_RELOCK && m_phase != 0) np = 0;
      else begin
        case (m_phase)
          0: if (m_t + 1 == ARST) np = 1;
          1: begin
            if (m_t + 1 == TMO) begin np = 0; m_err = 1; end
            else if (ls) np = 2;
          end
          2: begin
            if (!ls) np = 1;
            else if (m_t + 1 == STAB) np = 3;
          end
          default: begin
            if (run == FILT) begin np = 1; lost = 1; end
            else if (m_phase == 3 && m_t + 1 == GAP) np = 4;
          end
        endcase
      end
      if (lost && m_loss < 255) m_loss++;
      m_low   = (np >= 3) ? run : 0;
      m_t     = (np != m_phase) ? 0 : m_t + 1;
      m_phase = np;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",       32'(STATE),         32'(m_phase));
    chk("pll_arst_n",  32'(PLL_ARST_N),    32'(m_phase != 0));
    chk("gl0_reset_n", 32'(GL0_RESET_N),   32'(m_phase >= 3));
    chk("gl1_reset_n", 32'(GL1_RESET_N),   32'(m_phase == 4));
    chk("ready",       32'(READY),         32'(m_phase == 4));
    chk("loss_cnt",    32'(LOCK_LOSS_CNT), 32'(m_loss));
    chk("timeout_err", 32'(TIMEOUT_ERR),   32'(m_err));
    chk("gl1_implies_gl0", 32'(GL1_RESET_N & ~GL0_RESET_N), 32'd0);
  endtask

  task automatic cycle();
    @(posedge CLK0);
    @(negedge CLK0);
    check_all();
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return PLL_ARST_N;
      1:       return GL0_RESET_N;
      2:       return GL1_RESET_N;
      3:       return READY;
      4:       return STATE == 3'd2;
      default: return STATE == 3'd1;
    endcase
  endfunction

  task automatic count_until(input int w, input logic level, input int limit, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (sel(w) !== level && n < limit);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin : stim
    int n;
    int runlen;

    // Scenario 1: power-up sequence with LOCK held high
    repeat (4) cycle();
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_pll", 32'(PLL_ARST_N), 32'd0);
    RESET = 1'b0;
    count_until(0, 1'b1, 50, n);  chk("s1_pll_low", 32'(n), 32'd8);
    count_until(1, 1'b1, 100, n); chk("s1_gl0_gap", 32'(n), 32'd17);
    count_until(2, 1'b1, 50, n);  chk("s1_gl1_gap", 32'(n), 32'd4);
    chk("s1_ready", 32'(READY), 32'd1);

    // Scenario 2: 3-cycle glitch is filtered, 4-cycle drop is a lock loss
    LOCK = 1'b0; repeat (3) cycle();
    LOCK = 1'b1; repeat (6) cycle();
    chk("s2_glitch_ready", 32'(READY), 32'd1);
    chk("s2_glitch_cnt", 32'(LOCK_LOSS_CNT), 32'd0);
    LOCK = 1'b0;
    count_until(3, 1'b0, 20, n);  chk("s2_loss_latency", 32'(n), 32'd6);
    chk("s2_state", 32'(STATE), 32'd1);
    chk("s2_gl0", 32'(GL0_RESET_N), 32'd0);
    chk("s2_gl1", 32'(GL1_RESET_N), 32'd0);
    chk("s2_cnt", 32'(LOCK_LOSS_CNT), 32'd1);

    // Scenario 4: one synced-low cycle at STABLE count 10 restarts qualification
    LOCK = 1'b1;
    count_until(4, 1'b1, 20, n);
    chk("s4_enter_stable", 32'(STATE), 32'd2);
    repeat (8) cycle();
    LOCK = 1'b0; cycle();
    LOCK = 1'b1;
    count_until(5, 1'b1, 10, n);  chk("s4_drop_latency", 32'(n), 32'd2);
    count_until(4, 1'b1, 10, n);  chk("s4_reenter", 32'(n), 32'd1);
    count_until(1, 1'b1, 50, n);  chk("s4_full_stable", 32'(n), 32'd16);
    count_until(2, 1'b1, 20, n);  chk("s4_gl1_gap", 32'(n), 32'd4);

    // Scenario 5: FORCE_RELOCK in RUN, second pulse inside PLL_RST is ignored
    FORCE_RELOCK = 1'b1; cycle(); FORCE_RELOCK = 1'b0;
    chk("s5_state", 32'(STATE), 32'd0);
    chk("s5_pll", 32'(PLL_ARST_N), 32'd0);
    chk("s5_gl0", 32'(GL0_RESET_N), 32'd0);
    chk("s5_gl1", 32'(GL1_RESET_N), 32'd0);
    chk("s5_cnt", 32'(LOCK_LOSS_CNT), 32'd1);
    n = 0;
    do begin
      FORCE_RELOCK = (n == 3);
      cycle();
      n++;
    end while (PLL_ARST_N !== 1'b1 && n < 50);
    FORCE_RELOCK = 1'b0;
    chk("s5_pll_window", 32'(n), 32'd8);
    count_until(1, 1'b1, 100, n); chk("s5_gl0_gap", 32'(n), 32'd17);
    count_until(2, 1'b1, 50, n);  chk("s5_gl1_gap", 32'(n), 32'd4);

    // Scenario 3: LOCK never arrives -> timeout loop
    LOCK = 1'b0;
    RESET = 1'b1; repeat (4) cycle();
    chk("s3_rst_cnt", 32'(LOCK_LOSS_CNT), 32'd0);
    chk("s3_rst_err", 32'(TIMEOUT_ERR), 32'd0);
    chk("s3_rst_ready", 32'(READY), 32'd0);
    RESET = 1'b0;
    count_until(0, 1'b1, 50, n);  chk("s3_pll_low1", 32'(n), 32'd8);
    chk("s3_err_before", 32'(TIMEOUT_ERR), 32'd0);
    count_until(0, 1'b0, 200, n); chk("s3_wait1", 32'(n), 32'd100);
    chk("s3_err1", 32'(TIMEOUT_ERR), 32'd1);
    count_until(0, 1'b1, 50, n);  chk("s3_pll_low2", 32'(n), 32'd8);
    count_until(0, 1'b0, 200, n); chk("s3_wait2", 32'(n), 32'd100);
    chk("s3_err2", 32'(TIMEOUT_ERR), 32'd1);
    chk("s3_gl0", 32'(GL0_RESET_N), 32'd0);

    // Randomized LOCK runs and rare FORCE_RELOCK pulses
    runlen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (runlen == 0) begin
        LOCK   = ~LOCK;
        runlen = LOCK ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 8));
      end
      runlen--;
      FORCE_RELOCK = ($urandom_range(0, 199) == 0);
      cycle();
    end
    FORCE_RELOCK = 1'b0;

    // Scenario 6: saturate the loss counter, then reset mid-run
    for (int i = 0; i < 257; i++) begin
      LOCK = 1'b1;
      n = 0;
      while (READY !== 1'b1 && n < 200) begin cycle(); n++; end
      chk("s6_reach_run", 32'(READY), 32'd1);
      LOCK = 1'b0;
      n = 0;
      while (READY !== 1'b0 && n < 20) begin cycle(); n++; end
      chk("s6_loss", 32'(READY), 32'd0);
    end
    chk("s6_saturated", 32'(LOCK_LOSS_CNT), 32'd255);
    LOCK = 1'b1;
    n = 0;
    while (READY !== 1'b1 && n < 200) begin cycle(); n++; end
    chk("s6_run_again", 32'(READY), 32'd1);
    RESET = 1'b1; cycle();
    chk("s6_rst_state", 32'(STATE), 32'd0);
    chk("s6_rst_pll", 32'(PLL_ARST_N), 32'd0);
    chk("s6_rst_gl0", 32'(GL0_RESET_N), 32'd0);
    chk("s6_rst_gl1", 32'(GL1_RESET_N), 32'd0);
    chk("s6_rst_ready", 32'(READY), 32'd0);
    chk("s6_rst_cnt", 32'(LOCK_LOSS_CNT), 32'd0);
    chk("s6_rst_err", 32'(TIMEOUT_ERR), 32'd0);
    RESET = 1'b0;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
